// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
//   Shared definitions for the dispense controller:
//     - RSP_W and the response status codes (ST_OK .. ST_BAD_ITEM)
//     - FSM state encoding (state_e)
//     - max3() helper used to size the shared timer
// -----------------------------------------------------------------------------
package vend_pkg;

  localparam int RSP_W = 3;

  localparam logic [RSP_W-1:0] ST_OK           = 3'd0;
  localparam logic [RSP_W-1:0] ST_OUT_OF_STOCK = 3'd1;
  localparam logic [RSP_W-1:0] ST_NOT_PRESENT  = 3'd2;
  localparam logic [RSP_W-1:0] ST_JAM          = 3'd3;
  localparam logic [RSP_W-1:0] ST_BAD_ITEM     = 3'd4;

  // S_PAUSE is the motor-off gap between attempts. It is only reachable when
  // the retry feature is compiled in.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD     = 4'd1,
    S_WAIT   = 4'd2,
    S_CHECK  = 4'd3,
    S_MOTOR  = 4'd4,
    S_SETTLE = 4'd5,
    S_WB     = 4'd6,
    S_RSP    = 4'd7,
    S_PAUSE  = 4'd8
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_sync2.sv
// -----------------------------------------------------------------------------
// vend_sync2
//   Two-flop synchroniser for asynchronous level inputs. The design uses it for
//   the slot sensors, the chute drop sensor, and as the reset-release
//   synchroniser (i_d tied high).
// Ports
//   clk    in   1      destination clock
//   rst_n  in   1      async active-low reset; clears both stages
//   i_d    in   WIDTH  asynchronous input
//   o_q    out  WIDTH  synchronised output, two clk edges of latency
// -----------------------------------------------------------------------------
module vend_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make the two stages shift one edge
      // apart. Blocking assignments would collapse them into a single flop.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// vend_dispense_ctrl
//   Dispense controller. It accepts one item command at a time and reads that
//   item's stock from the inventory RAM. It then checks the slot sensor and
//   drives the item's motor until the chute drop sensor fires or the motor
//   times out. After a settle period it writes back stock-1 and emits one
//   response pulse.
//
// Build option
//   VEND_RETRY_EN  when defined, a motor timeout triggers a SETTLE_TIME pause
//                  and another attempt, up to two retries. JAM is reported only
//                  after the third timeout. When undefined, the first timeout
//                  reports JAM.
//
// Ports
//   clk, rst_n           clock, async active-low reset (released synchronously)
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_item             requested slot, captured on acceptance
//   inv_addr/inv_rd_en   inventory read (1-cycle strobe)
//   inv_rdata            stock word, valid INV_RD_LAT cycles after the strobe
//   inv_we/inv_wdata     inventory write-back (1-cycle strobe, stock-1)
//   item_sensors         per-slot presence (asynchronous level)
//   drop_sensor          chute drop detector (asynchronous)
//   dispense_motors      one-hot motor drive
//   busy                 high whenever not IDLE
//   rsp_valid            1-cycle completion pulse
//   rsp_status/rsp_item  result and slot, held until the next response
// -----------------------------------------------------------------------------
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS     = 16,
  parameter int ITEM_W        = 8,
  parameter int STOCK_W       = 16,
  parameter int INV_RD_LAT    = 1,
  parameter int DISPENSE_TIME = 50000000,
  parameter int SETTLE_TIME   = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ITEM_W-1:0]    cmd_item,
  output logic [ITEM_W-1:0]    inv_addr,
  output logic                 inv_rd_en,
  input  logic [STOCK_W-1:0]   inv_rdata,
  output logic                 inv_we,
  output logic [STOCK_W-1:0]   inv_wdata,
  input  logic [NUM_ITEMS-1:0] item_sensors,
  input  logic                 drop_sensor,
  output logic [NUM_ITEMS-1:0] dispense_motors,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [RSP_W-1:0]     rsp_status,
  output logic [ITEM_W-1:0]    rsp_item
);

  // One timer serves WAIT, MOTOR, SETTLE and PAUSE. It is sized for the
  // longest of those intervals.
  localparam int TMR_W = $clog2(max3(DISPENSE_TIME, SETTLE_TIME, INV_RD_LAT) + 1);
  localparam int IDX_W = $clog2(NUM_ITEMS);

  localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0]   LAT_LAST    = TMR_W'(INV_RD_LAT - 1);
  localparam logic [TMR_W-1:0]   DISP_LAST   = TMR_W'(DISPENSE_TIME - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_TIME - 1);
  localparam logic [STOCK_W-1:0] STOCK_ONE   = STOCK_W'(1);

  // ---------------------------------------------------------------------------
  // Reset and input synchronisation
  // ---------------------------------------------------------------------------
  logic                 w_rst_n;
  logic [NUM_ITEMS-1:0] w_sensors;
  logic                 w_drop_s;
  logic                 r_drop_prev;
  logic                 w_drop_evt;

  // Asserts asynchronously with rst_n and releases two edges later, so every
  // state flop leaves reset on the same clock edge.
  vend_sync2 #(.WIDTH(1)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (1'b1),
    .o_q   (w_rst_n)
  );

  vend_sync2 #(.WIDTH(NUM_ITEMS)) u_sensor_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (item_sensors),
    .o_q   (w_sensors)
  );

  vend_sync2 #(.WIDTH(1)) u_drop_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (drop_sensor),
    .o_q   (w_drop_s)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_drop_prev <= 1'b0;
    else          r_drop_prev <= w_drop_s;
  end

  // Only a rising edge counts. A sensor still held high from an earlier drop
  // cannot satisfy a later motor attempt.
  assign w_drop_evt = w_drop_s & ~r_drop_prev;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e               r_state;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic [ITEM_W-1:0]    r_item;
  logic [STOCK_W-1:0]   r_stock;
  logic [TMR_W-1:0]     r_timer;
  logic [ITEM_W-1:0]    r_inv_addr;
  logic                 r_inv_rd_en;
  logic                 r_inv_we;
  logic [STOCK_W-1:0]   r_inv_wdata;
  logic [NUM_ITEMS-1:0] r_motors;
  logic                 r_rsp_valid;
  logic [RSP_W-1:0]     r_rsp_status;
  logic [ITEM_W-1:0]    r_rsp_item;
`ifdef VEND_RETRY_EN
  logic [1:0]           r_retry;
`endif

  logic [IDX_W-1:0]     w_idx;
  logic [NUM_ITEMS-1:0] w_onehot;
  logic                 w_bad_item;

  // Items are range-checked on acceptance, so the low bits index the slot.
  assign w_idx      = r_item[IDX_W-1:0];
  assign w_onehot   = NUM_ITEMS'(1) << w_idx;
  assign w_bad_item = (32'(cmd_item) >= NUM_ITEMS);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      // NOTE: every register, datapath included, has a reset value. Reset
      // stops the motor the moment it is asserted, and outputs never show X.
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_item       <= '0;
      r_stock      <= '0;
      r_timer      <= '0;
      r_inv_addr   <= '0;
      r_inv_rd_en  <= 1'b0;
      r_inv_we     <= 1'b0;
      r_inv_wdata  <= '0;
      r_motors     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
      r_rsp_item   <= '0;
`ifdef VEND_RETRY_EN
      r_retry      <= 2'd0;
`endif
    end else begin
      // Strobes default low, so each branch that raises one raises it for
      // exactly one cycle.
      r_inv_rd_en <= 1'b0;
      r_inv_we    <= 1'b0;
      r_rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_item      <= cmd_item;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef VEND_RETRY_EN
            r_retry     <= 2'd0;
`endif
            if (w_bad_item) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_BAD_ITEM;
              r_rsp_item   <= cmd_item;
              r_state      <= S_RSP;
            end else begin
              r_inv_rd_en <= 1'b1;
              r_inv_addr  <= cmd_item;
              r_state     <= S_RD;
            end
          end
        end

        S_RD: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end

        // The stock word is valid in the last WAIT cycle and is sampled there.
        S_WAIT: begin
          if (r_timer == LAT_LAST) begin
            r_stock <= inv_rdata;
            r_state <= S_CHECK;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

        S_CHECK: begin
          if (r_stock == '0) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= ST_OUT_OF_STOCK;
            r_rsp_item   <= r_item;
            r_state      <= S_RSP;
          end else if (!w_sensors[w_idx]) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= ST_NOT_PRESENT;
            r_rsp_item   <= r_item;
            r_state      <= S_RSP;
          end else begin
            r_motors <= w_onehot;
            r_timer  <= '0;
            r_state  <= S_MOTOR;
          end
        end

        // The drop check comes first, so a drop on the timeout cycle still
        // counts as a successful dispense.
        S_MOTOR: begin
          if (w_drop_evt) begin
            r_motors <= '0;
            r_timer  <= '0;
            r_state  <= S_SETTLE;
          end else if (r_timer == DISP_LAST) begin
            r_motors <= '0;
`ifdef VEND_RETRY_EN
            if (r_retry != 2'd2) begin
              r_retry <= r_retry + 2'd1;
              r_timer <= '0;
              r_state <= S_PAUSE;
            end else begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_JAM;
              r_rsp_item   <= r_item;
              r_state      <= S_RSP;
            end
`else
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= ST_JAM;
            r_rsp_item   <= r_item;
            r_state      <= S_RSP;
`endif
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

`ifdef VEND_RETRY_EN
        // Motor-off gap before the next attempt. Drops here are ignored.
        S_PAUSE: begin
          if (r_timer == SETTLE_LAST) begin
            r_motors <= w_onehot;
            r_timer  <= '0;
            r_state  <= S_MOTOR;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
`endif

        // Motor off while the item clears the chute. Drops here are ignored.
        S_SETTLE: begin
          if (r_timer == SETTLE_LAST) begin
            r_inv_we    <= 1'b1;
            r_inv_wdata <= r_stock - STOCK_ONE;
            r_state     <= S_WB;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

        S_WB: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_status <= ST_OK;
          r_rsp_item   <= r_item;
          r_state      <= S_RSP;
        end

        S_RSP: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_motors    <= '0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign busy            = r_busy;
  assign inv_addr        = r_inv_addr;
  assign inv_rd_en       = r_inv_rd_en;
  assign inv_we          = r_inv_we;
  assign inv_wdata       = r_inv_wdata;
  assign dispense_motors = r_motors;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_status      = r_rsp_status;
  assign rsp_item        = r_rsp_item;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_ctrl
//   Self-checking bench for vend_dispense_ctrl. It uses a small inventory RAM
//   with INV_RD_LAT read latency and a reference model of each command's
//   outcome. Directed cases are followed by randomized commands.
// -----------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

  localparam int NI     = 16;
  localparam int IW     = 8;
  localparam int SW     = 16;
  localparam int LAT    = 2;
  localparam int DT     = 100;
  localparam int STL    = 4;
  localparam int BUDGET = 1000;
`ifdef VEND_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  // Status codes as defined for rsp_status.
  localparam int E_OK = 0, E_OOS = 1, E_NP = 2, E_JAM = 3, E_BAD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_item;
  logic [IW-1:0] inv_addr;
  logic          inv_rd_en;
  logic [SW-1:0] inv_rdata;
  logic          inv_we;
  logic [SW-1:0] inv_wdata;
  logic [NI-1:0] item_sensors;
  logic          drop_sensor;
  logic [NI-1:0] dispense_motors;
  logic          busy;
  logic          rsp_valid;
  logic [2:0]    rsp_status;
  logic [IW-1:0] rsp_item;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .NUM_ITEMS     (NI),
    .ITEM_W        (IW),
    .STOCK_W       (SW),
    .INV_RD_LAT    (LAT),
    .DISPENSE_TIME (DT),
    .SETTLE_TIME   (STL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_item        (cmd_item),
    .inv_addr        (inv_addr),
    .inv_rd_en       (inv_rd_en),
    .inv_rdata       (inv_rdata),
    .inv_we          (inv_we),
    .inv_wdata       (inv_wdata),
    .item_sensors    (item_sensors),
    .drop_sensor     (drop_sensor),
    .dispense_motors (dispense_motors),
    .busy            (busy),
    .rsp_valid       (rsp_valid),
    .rsp_status      (rsp_status),
    .rsp_item        (rsp_item)
  );

  // ---------------- inventory RAM (environment) ----------------
  logic [SW-1:0] mem [NI];
  logic          tb_we;
  logic [3:0]    tb_addr;
  logic [SW-1:0] tb_data;
  logic          pipe_v [LAT];
  logic [SW-1:0] pipe_d [LAT];

  always @(posedge clk) begin
    if (inv_we) mem[inv_addr[3:0]] <= inv_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
    pipe_v[0] <= inv_rd_en;
    pipe_d[0] <= mem[inv_addr[3:0]];
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  // Read data is valid only INV_RD_LAT cycles after the strobe. At any other
  // time the RAM returns garbage.
  assign inv_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hDEAD;

  // ---------------- reference state ----------------
  int ref_stock [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input int item, input int val);
    tb_addr = 4'(item);
    tb_data = 16'(val);
    tb_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_we = 1'b0;
    ref_stock[item] = val;
  endtask

  // Issue one command and predict its result from the rules. drop_k > 0 raises
  // drop_sensor once the motor has been seen on for drop_k cycles. After the
  // two synchroniser stages the motor stops drop_k+2 cycles in. hold keeps
  // cmd_valid asserted, for back-to-back commands.
  task automatic run_cmd(input int item, input bit present, input int drop_k, input bit hold);
    int exp_st, exp_rd, exp_we, exp_m, exp_busy, exp_wd;
    int mcnt, rd_n, we_n, busy_n, wd, n;
    bit onehot_ok, ready_ok, addr_ok, got;
    logic [2:0] st;
    logic [IW-1:0] ri;
    mcnt = 0; rd_n = 0; we_n = 0; busy_n = 0; wd = 0;
    onehot_ok = 1; ready_ok = 1; addr_ok = 1; got = 0;
    st = '0; ri = '0;

    exp_rd = 1; exp_we = 0; exp_m = 0; exp_wd = 0;
    if (item >= NI) begin
      exp_st = E_BAD; exp_rd = 0; exp_busy = 1;
    end else if (ref_stock[item] == 0) begin
      exp_st = E_OOS; exp_busy = 1 + LAT + 1 + 1;
    end else if (!present) begin
      exp_st = E_NP; exp_busy = 1 + LAT + 1 + 1;
    end else if (drop_k >= 1 && drop_k <= DT - 2) begin
      exp_st = E_OK; exp_m = drop_k + 2; exp_we = 1; exp_wd = ref_stock[item] - 1;
      exp_busy = 1 + LAT + 1 + exp_m + STL + 2;
    end else begin
      exp_st = E_JAM; exp_m = DT * ATTEMPTS;
      exp_busy = 1 + LAT + 1 + exp_m + (ATTEMPTS - 1) * STL + 1;
    end

    item_sensors = 16'($urandom);
    if (item < NI) item_sensors[item] = present;
    cmd_item  = IW'(item);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait[%0d]", item), cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;

    for (int c = 0; c < BUDGET; c++) begin
      if (busy) busy_n++;
      if (busy && cmd_ready) ready_ok = 0;
      if (dispense_motors != '0) begin
        mcnt++;
        if (item >= NI || dispense_motors != (16'd1 << item)) onehot_ok = 0;
        if (mcnt == drop_k) drop_sensor = 1'b1;
      end
      if (inv_rd_en) begin
        rd_n++;
        if (inv_addr != IW'(item)) addr_ok = 0;
      end
      if (inv_we) begin
        we_n++;
        wd = int'(inv_wdata);
        if (inv_addr != IW'(item)) addr_ok = 0;
      end
      if (rsp_valid) begin
        got = 1; st = rsp_status; ri = rsp_item;
        break;
      end
      @(negedge clk);
    end
    drop_sensor = 1'b0;

    check($sformatf("rsp_seen[%0d]", item), got, 1);
    check($sformatf("status[%0d]", item), st, exp_st);
    check($sformatf("rsp_item[%0d]", item), ri, IW'(item));
    check($sformatf("rd_strobes[%0d]", item), rd_n, exp_rd);
    check($sformatf("we_strobes[%0d]", item), we_n, exp_we);
    check($sformatf("motor_cycles[%0d]", item), mcnt, exp_m);
    check($sformatf("busy_cycles[%0d]", item), busy_n, exp_busy);
    check($sformatf("motor_onehot[%0d]", item), onehot_ok, 1);
    check($sformatf("ready_low_busy[%0d]", item), ready_ok, 1);
    check($sformatf("inv_addr[%0d]", item), addr_ok, 1);
    if (exp_we == 1) check($sformatf("wdata[%0d]", item), wd, exp_wd);
    if (exp_st == E_OK) ref_stock[item] = ref_stock[item] - 1;

    if (!hold) begin
      @(negedge clk);
      check($sformatf("rsp_one_cycle[%0d]", item), rsp_valid, 0);
      check($sformatf("idle_ready[%0d]", item), cmd_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rsp_n, we_n, wait_n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_item = '0; item_sensors = '0;
    drop_sensor = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    for (int i = 0; i < NI; i++) ref_stock[i] = 0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_motors", dispense_motors, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_en", inv_rd_en, 0);
    check("rst_we", inv_we, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NI; i++) preload(i, $urandom_range(1, 3));

    // 1: stock 5, motor stopped at motor cycle 20 by the drop.
    preload(3, 5);
    run_cmd(3, 1, 18, 0);
    check("t1_mem3", mem[3], 4);

    // 2: out of stock, then slot empty.
    preload(7, 0);
    run_cmd(7, 1, 18, 0);
    run_cmd(5, 0, 18, 0);

    // 3: no drop, so the dispense jams.
    run_cmd(2, 1, 0, 0);

    // 4: item index out of range.
    run_cmd(20, 1, 0, 0);

    // 5: reset while the motor runs.
    preload(4, 3);
    item_sensors[4] = 1'b1;
    cmd_item = 8'd4; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    wait_n = 0;
    while (dispense_motors == '0 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("t5_motor_started", dispense_motors, 16'h0010);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_motors_off", dispense_motors, 0);
    check("t5_busy_off", busy, 0);
    rsp_n = 0; we_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
      if (inv_we) we_n++;
    end
    check("t5_no_rsp", rsp_n, 0);
    check("t5_no_write", we_n, 0);
    check("t5_ready_after", cmd_ready, 1);

    // 6: a drop landing exactly on the timeout cycle still succeeds. A drop
    //    one cycle later is a jam.
    preload(9, 2);
    run_cmd(9, 1, DT - 2, 0);
    preload(10, 2);
    run_cmd(10, 1, DT - 1, 0);

    // 6b: cmd_valid held across two commands.
    preload(1, 2);
    preload(6, 1);
    run_cmd(1, 1, 30, 1);
    run_cmd(6, 1, 40, 0);

    // Randomized commands.
    for (int k = 0; k < 20; k++) begin
      int it, dk;
      bit pr;
      it = $urandom_range(0, 19);
      pr = ($urandom_range(0, 3) != 0);
      dk = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, DT - 2);
      if (it < NI && $urandom_range(0, 2) == 0) preload(it, $urandom_range(0, 3));
      run_cmd(it, pr, dk, 0);
    end

    for (int i = 0; i < NI; i++) check($sformatf("final_stock[%0d]", i), mem[i], ref_stock[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
